// File: rtl/seq_transmitter.sv
// Serial frame transmitter: header, one guard bit, then the payload MSB first; idle line is 0.
// Moore outputs decoded from registered state; every state change is qualified by clk_en.
module seq_transmitter #(
  parameter int                 DATA_W  = 8,
  parameter int                 HDR_W   = 6,
  parameter logic [HDR_W-1:0]   HDR_PAT = 6'b110101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ser_out,
  output logic              busy,
  output logic              payload_active,
  output logic              done
);

  localparam int MAX_W    = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int CNT_SPAN = 1 << CNT_W;

  // Header bit-reversed and zero-padded so the bit counter indexes it directly.
  localparam logic [HDR_W-1:0]    HDR_REV   = {<<{HDR_PAT}};
  localparam logic [CNT_SPAN-1:0] HDR_TAB   = CNT_SPAN'(HDR_REV);
  localparam logic [CNT_W-1:0]    HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_GUARD = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
          shift_d = data_in;
        end
      end
      S_HDR: begin
        if (cnt_q == HDR_LAST) begin
          state_d = S_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        shift_d = shift_q << 1;
        if (cnt_q == DATA_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // DONE never samples start, so frames are always separated by a 0 bit.
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  always_comb begin
    ser_out        = 1'b0;
    busy           = 1'b0;
    payload_active = 1'b0;
    done           = 1'b0;
    case (state_q)
      S_HDR: begin
        ser_out = HDR_TAB[cnt_q];
        busy    = 1'b1;
      end
      S_GUARD: begin
        busy = 1'b1;
      end
      S_DATA: begin
        ser_out        = shift_q[DATA_W-1];
        busy           = 1'b1;
        payload_active = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        ser_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_transmitter.sv
// Bench for seq_transmitter: per-period frame model plus a behavioural header-hunting receiver.
module tb_seq_transmitter;

  localparam int         DW  = 8;
  localparam int         HW  = 6;
  localparam int         FRM = 2 + HW + DW;  // periods from first header bit through DONE
  localparam logic [5:0] HDR = 6'b110101;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       start;
  logic [7:0] data_in;
  logic       ser_out;
  logic       busy;
  logic       payload_active;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_transmitter #(
    .DATA_W (DW),
    .HDR_W  (HW),
    .HDR_PAT(6'b110101)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .start         (start),
    .data_in       (data_in),
    .ser_out       (ser_out),
    .busy          (busy),
    .payload_active(payload_active),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {ser_out, busy, payload_active, done} in period p after the accepting edge.
  function automatic logic [3:0] exp_outs(input logic [7:0] d, input int p);
    logic [15:0] frame;
    logic [15:0] t;
    logic        s;
    frame = {HDR, 1'b0, d, 1'b0};
    if (p < 0 || p >= FRM) return 4'b0000;
    t = frame >> (FRM - 1 - p);
    s = t[0];
    return {s, 1'b1, (p >= HW + 1 && p < HW + 1 + DW), (p == FRM - 1)};
  endfunction

  function automatic logic [3:0] obs();
    return {ser_out, busy, payload_active, done};
  endfunction

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; data_in = 8'h00;
    #3;
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_assert outs=%b want=0000", obs());
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'($urandom);
      tick();
      checks++;
      if (obs() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d outs=%b want=0000", i, obs());
      end
    end
  endtask

  task automatic test_basic_frame();
    clk_en = 1'b1; data_in = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < FRM + 2; p++) begin
      checks++;
      if (obs() !== exp_outs(8'hA5, p)) begin
        errors++;
        $display("FAIL basic_frame p=%0d outs=%b want=%b", p, obs(), exp_outs(8'hA5, p));
      end
      data_in = 8'($urandom);
      tick();
    end
  endtask

  task automatic test_enable_gating();
    int hold;
    clk_en = 1'b1; data_in = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < FRM; p++) begin
      // Period 9 is the third payload bit: stretch it with 10 extra disabled clocks.
      hold = (p == 9) ? 13 : 3;
      for (int k = 0; k < hold; k++) begin
        checks++;
        if (obs() !== exp_outs(8'hFF, p)) begin
          errors++;
          $display("FAIL enable_gating p=%0d k=%0d outs=%b want=%b", p, k, obs(), exp_outs(8'hFF, p));
        end
        clk_en = (k == hold - 1);
        start  = (k == 0);
        tick();
      end
    end
    start = 1'b0;
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL enable_gating_end outs=%b want=0000", obs());
    end
  endtask

  task automatic test_start_while_busy();
    clk_en = 1'b1; data_in = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < FRM + 2; p++) begin
      checks++;
      if (obs() !== exp_outs(8'h0F, p)) begin
        errors++;
        $display("FAIL busy_ignore p=%0d outs=%b want=%b", p, obs(), exp_outs(8'h0F, p));
      end
      start   = (p == 8) || (p == FRM - 1);
      data_in = 8'hF0;
      tick();
    end
    start = 1'b0;
    data_in = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < FRM + 1; p++) begin
      checks++;
      if (obs() !== exp_outs(8'h3C, p)) begin
        errors++;
        $display("FAIL next_frame p=%0d outs=%b want=%b", p, obs(), exp_outs(8'h3C, p));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    clk_en = 1'b1; data_in = 8'hC3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 9; p++) tick();
    checks++;
    if (obs() !== exp_outs(8'hC3, 9)) begin
      errors++;
      $display("FAIL pre_reset outs=%b want=%b", obs(), exp_outs(8'hC3, 9));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset outs=%b want=0000", obs());
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle outs=%b want=0000", obs());
    end
    data_in = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < FRM + 1; p++) begin
      checks++;
      if (obs() !== exp_outs(8'h5A, p)) begin
        errors++;
        $display("FAIL fresh_frame p=%0d outs=%b want=%b", p, obs(), exp_outs(8'h5A, p));
      end
      tick();
    end
  endtask

  task automatic test_loopback();
    logic [5:0] win;
    logic [7:0] rx_word;
    logic [7:0] payload;
    int         rx_mode;  // 0 hunt header, 1 skip guard, 2 collect payload
    int         rx_cnt;
    int         budget;
    bit         got;
    win = '0; rx_mode = 0; rx_cnt = 0; rx_word = '0;
    for (int f = 0; f < 20; f++) begin
      payload = 8'($urandom);
      got     = 1'b0;
      clk_en  = 1'b1; data_in = payload; start = 1'b1;
      tick();
      start  = 1'b0;
      budget = 300;
      while (budget > 0) begin
        budget--;
        clk_en  = ($urandom_range(0, 3) != 0);
        data_in = 8'($urandom);
        if (clk_en) begin
          case (rx_mode)
            0: begin
              win = {win[4:0], ser_out};
              if (win == HDR) rx_mode = 1;
            end
            1: begin
              rx_mode = 2;
              rx_cnt  = 0;
            end
            default: begin
              rx_word = {rx_word[6:0], ser_out};
              rx_cnt++;
              if (rx_cnt == DW) begin
                rx_mode = 0;
                win     = '0;
                got     = 1'b1;
              end
            end
          endcase
        end
        tick();
        if (!busy) break;
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL loopback_timeout frame=%0d busy=%b want=0", f, busy);
      end
      checks++;
      if (!got || rx_word !== payload) begin
        errors++;
        $display("FAIL loopback_data frame=%0d got=%0b rx=%h want=%h", f, got, rx_word, payload);
      end
      checks++;
      if (rx_mode != 0) begin
        errors++;
        $display("FAIL loopback_rx_idle frame=%0d mode=%0d want=0", f, rx_mode);
      end
    end
    clk_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; start = 1'b0; data_in = 8'h00;
    test_reset();
    test_basic_frame();
    test_enable_gating();
    test_start_while_busy();
    test_reset_mid_frame();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
